// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision format constants and types
package fp_pkg;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_t;
    typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, NORM} fp_div_state_t;
endpackage

// File: rtl/fp_div_mantissa.sv
// fp_div_mantissa: 25-step restoring mantissa divider, one quotient bit per step
module fp_div_mantissa (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic [24:0] q,
    output logic [25:0] rem,
    output logic        last
);
    logic [4:0] cnt;
    assign last = cnt == 5'd24;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= '0;
            rem <= {2'b00, mant_a};
            cnt <= '0;
        end else if (step) begin
            q   <= {q[23:0], rem >= {2'b00, mant_b}};
            rem <= (rem >= {2'b00, mant_b}) ? (rem - {2'b00, mant_b}) << 1 : rem << 1;
            cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: rtl/fp_divider.sv
// fp_divider: iterative single-precision divider, truncating, subnormals flushed to zero
module fp_divider
    import fp_pkg::*;
#(
    parameter int EXP_BIAS = FP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot
);
    fp_t a, b;
    fp_div_state_t state;
    logic s, is_special, sign_r, last;
    logic [31:0] spec_val, spec_r, norm_val;
    logic signed [9:0] exp_r, fe;
    logic [22:0] frac;
    logic [24:0] q;
    logic [25:0] rem_unused;
    assign a = in_a;
    assign b = in_b;
    assign s = a.sign ^ b.sign;
    fp_div_mantissa u_mant (
        .clk    (clk),
        .rst    (rst),
        .load   (state == IDLE && start),
        .step   (state == DIVIDE),
        .mant_a ({1'b1, a.frac}),
        .mant_b ({1'b1, b.frac}),
        .q      (q),
        .rem    (rem_unused),
        .last   (last)
    );
    always_comb begin
        is_special = a.exp == 8'hFF || b.exp == 8'hFF || a.exp == 8'h00 || b.exp == 8'h00;
        spec_val   = (a.exp == 8'hFF || b.exp == 8'hFF || (a.exp == 8'h00 && b.exp == 8'h00)) ? FP_QNAN :
                     (b.exp == 8'h00) ? {s, 8'hFF, 23'h0} : {s, 31'h0};
        // a quotient below 1 leaves the integer bit clear and costs one exponent step
        fe         = q[24] ? exp_r : exp_r - 10'sd1;
        frac       = q[24] ? q[23:1] : q[22:0];
        norm_val   = (fe >= 10'sd255) ? {sign_r, 8'hFF, 23'h0} :
                     (fe <= 10'sd0)   ? {sign_r, 31'h0} : {sign_r, fe[7:0], frac};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            quot   <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            spec_r <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= is_special ? SPECIAL : DIVIDE;
                    busy   <= 1'b1;
                    sign_r <= s;
                    spec_r <= spec_val;
                    exp_r  <= {2'b00, a.exp} - {2'b00, b.exp} + 10'(EXP_BIAS);
                end
                DIVIDE: if (last) state <= NORM;
                SPECIAL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    quot  <= spec_r;
                end
                NORM: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    quot  <= norm_val;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed checks of fp_divider results, latency and control behaviour
module tb_fp_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic busy, done;
    logic [31:0] quot;
    int tests = 0;
    int fails = 0;
    int lat, bc;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .quot  (quot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int busy_cnt);
        l = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 l++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_quot", quot, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk) rst = 1'b0;

        issue(32'h40C00000, 32'h40000000);
        chk("6/2_busy_accept", {31'b0, busy}, 32'h1);
        wait_done(lat, bc);
        chk("6/2_quot", quot, 32'h40400000);
        chk("6/2_latency", lat, 26);
        chk("6/2_busy_cycles", bc + 1, 26);
        chk("6/2_busy_at_done", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1 chk("6/2_done_pulse", {31'b0, done}, 32'h0);

        issue(32'h3F800000, 32'h40400000);
        wait_done(lat, bc);
        chk("1/3_quot", quot, 32'h3EAAAAAA);
        chk("1/3_latency", lat, 26);

        issue(32'hBFC00000, 32'h40000000);
        wait_done(lat, bc);
        chk("neg_quot", quot, 32'hBF400000);

        issue(32'h3F800000, 32'h00000000);
        wait_done(lat, bc);
        chk("div0_quot", quot, 32'h7F800000);
        chk("div0_latency", lat, 1);

        issue(32'h00000000, 32'h00000000);
        wait_done(lat, bc);
        chk("0/0_quot", quot, 32'h7FC00000);
        chk("0/0_latency", lat, 1);

        issue(32'h80000000, 32'h3F800000);
        wait_done(lat, bc);
        chk("negzero_quot", quot, 32'h80000000);
        chk("negzero_latency", lat, 1);

        issue(32'h00800000, 32'h40000000);
        wait_done(lat, bc);
        chk("underflow_quot", quot, 32'h00000000);
        chk("underflow_latency", lat, 26);

        issue(32'h7F000000, 32'h3E800000);
        wait_done(lat, bc);
        chk("overflow_quot", quot, 32'h7F800000);

        issue(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #1;
        in_a  = 32'h3F800000;
        in_b  = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        chk("ignore_quot", quot, 32'h40400000);
        chk("ignore_latency", lat + 10, 26);

        issue(32'h3F800000, 32'h40400000);
        wait_done(lat, bc);
        chk("b2b_quot", quot, 32'h3EAAAAAA);
        chk("b2b_latency", lat, 26);

        issue(32'h40C00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_quot", quot, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        @(negedge clk) rst = 1'b0;
        wait_done(lat, bc);
        chk("rst_no_done", {31'b0, done}, 32'h0);
        chk("rst_quot_after", quot, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
